// File: rtl/tcm_arb_pkg.sv
// Shared types and constants for the two-port TCM arbiter.
package tcm_arb_pkg;
  localparam int NUM_PORTS = 2;
  localparam int DW        = 64;
  localparam int BEW       = DW / 8;
  localparam int DW_LSB    = $clog2(BEW);

  typedef struct packed {
    logic [31:0]    addr;
    logic           we;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] wbe;
  } tcm_req_t;

  // Doubleword index width for a TCM of the given byte size.
  function automatic int dw_idx_w(input int depth_bytes);
    return $clog2(depth_bytes) - DW_LSB;
  endfunction
endpackage

// File: rtl/tcm_port_arbiter_if.sv
// Requester-side bundle for tcm_port_arbiter; rsp_err exists only with TCM_ARB_RANGE_CHECK_EN.
interface tcm_port_arbiter_if;
  import tcm_arb_pkg::*;
  logic [NUM_PORTS-1:0]           req_vld;
  logic [NUM_PORTS-1:0]           req_rdy;
  logic [NUM_PORTS-1:0][31:0]     req_addr;
  logic [NUM_PORTS-1:0]           req_we;
  logic [NUM_PORTS-1:0][DW-1:0]   req_wdata;
  logic [NUM_PORTS-1:0][BEW-1:0]  req_wbe;
  logic [NUM_PORTS-1:0]           rsp_vld;
  logic [DW-1:0]                  rsp_rdata;
`ifdef TCM_ARB_RANGE_CHECK_EN
  logic                           rsp_err;
  modport master (output req_vld, req_addr, req_we, req_wdata, req_wbe,
                  input  req_rdy, rsp_vld, rsp_rdata, rsp_err);
  modport slave  (input  req_vld, req_addr, req_we, req_wdata, req_wbe,
                  output req_rdy, rsp_vld, rsp_rdata, rsp_err);
`else
  modport master (output req_vld, req_addr, req_we, req_wdata, req_wbe,
                  input  req_rdy, rsp_vld, rsp_rdata);
  modport slave  (input  req_vld, req_addr, req_we, req_wdata, req_wbe,
                  output req_rdy, rsp_vld, rsp_rdata);
`endif
endinterface

// File: rtl/tcm_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the requester that did not win last time wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gid
);
  always_comb begin
    gid = 1'b0;
    case (req)
      2'b10:   gid = 1'b1;
      2'b11:   gid = ~last;
      default: gid = 1'b0;
    endcase
    gnt = req & (gid ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/tcm_port_arbiter.sv
// Round-robin sharing of one single-port 64-bit TCM between two requesters.
// Optional address window decode with TCM_ARB_RANGE_CHECK_EN.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int          AW_TCM = 12,
  parameter logic [31:0] BASE   = 32'h9000_0000
) (
  input  logic               clk,
  input  logic               reset,
  tcm_port_arbiter_if.slave  bus,
  output logic               mem_cs,
  output logic               mem_we,
  output logic [AW_TCM-1:0]  mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [BEW-1:0]     mem_wbe,
  input  logic [DW-1:0]      mem_rdata
);
  logic       rr_last, rsp_pend, rsp_id;
  logic [1:0] gnt;
  logic       gid, accept, in_range;
  tcm_req_t   sel;

  rr_arb2 u_arb (.req(bus.req_vld), .last(rr_last), .gnt(gnt), .gid(gid));

  assign sel = '{addr: bus.req_addr[gid], we: bus.req_we[gid],
                 wdata: bus.req_wdata[gid], wbe: bus.req_wbe[gid]};

  assign accept      = |gnt;
  assign bus.req_rdy = gnt;

`ifdef TCM_ARB_RANGE_CHECK_EN
  logic rsp_err_q;
  logic unused_addr;
  assign in_range    = sel.addr[31:AW_TCM+DW_LSB] == BASE[31:AW_TCM+DW_LSB];
  assign unused_addr = ^sel.addr[DW_LSB-1:0];

  // Out-of-window requests still consume the response slot, flagged as errors.
  always_ff @(posedge clk or posedge reset)
    if (reset) rsp_err_q <= 1'b0;
    else       rsp_err_q <= accept & ~in_range;

  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_err_q ? '0 : mem_rdata;
`else
  logic unused_addr;
  assign in_range      = 1'b1;
  assign unused_addr   = ^{sel.addr[31:AW_TCM+DW_LSB], sel.addr[DW_LSB-1:0]};
  assign bus.rsp_rdata = mem_rdata;
`endif

  assign mem_cs    = accept & in_range;
  assign mem_we    = accept & sel.we;
  assign mem_wbe   = accept ? sel.wbe : '0;
  assign mem_addr  = sel.addr[AW_TCM+DW_LSB-1:DW_LSB];
  assign mem_wdata = sel.wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_last  <= 1'b1;
      rsp_pend <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      rsp_pend <= accept;
      if (accept) begin
        rr_last <= gid;
        rsp_id  <= gid;
      end
    end

  // Decoded from registers so an async reset kills a pending response at once.
  assign bus.rsp_vld = {rsp_pend & rsp_id, rsp_pend & ~rsp_id};
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Self-checking bench for tcm_port_arbiter: directed table, corner sequences, random vs. reference model.
`timescale 1ns/1ps
module tb_tcm_port_arbiter;
  import tcm_arb_pkg::*;
  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h9000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            mem_cs, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [63:0]     mem_wdata;
  logic [7:0]      mem_wbe;
  logic [63:0]     mem_rdata = '0;

  tcm_port_arbiter_if bus();

  tcm_port_arbiter #(.AW_TCM(AW), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wbe(mem_wbe), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM stand-in: 1-cycle read latency, byte-masked writes.
  logic [63:0] sram [0:(1<<AW)-1];
  always @(posedge clk)
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wbe);
      else        mem_rdata      <= sram[mem_addr];
    end

  typedef struct packed {
    logic [1:0] vld;
    tcm_req_t   p0;
    tcm_req_t   p1;
  } stim_t;

  typedef struct {
    bit          rst;
    bit          tchk;
    stim_t       s;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rsp;
    bit          chk_d;
    logic [63:0] e_d;
  } vec_t;

  int n_vec = 0, n_err = 0;

  // Reference model state: who won last, and what response is owed next cycle.
  bit          m_last, m_pend, m_id, m_err, m_dchk;
  logic [63:0] m_rd;
  logic [63:0] ref_mem [0:(1<<AW)-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
`ifdef TCM_ARB_RANGE_CHECK_EN
    return (a >> (AW + 3)) == (BASE >> (AW + 3));
`else
    return (a != 32'hFFFF_FFFF) || 1'b1;
`endif
  endfunction

  function automatic tcm_req_t rq(input logic [31:0] a, input bit we, input logic [63:0] d, input logic [7:0] be);
    tcm_req_t r;
    r.addr = a; r.we = we; r.wdata = d; r.wbe = be;
    return r;
  endfunction

  function automatic tcm_req_t rnd_req();
    logic [31:0] up, a;
    up = {$urandom} & 32'hFFFF_8000;
`ifdef TCM_ARB_RANGE_CHECK_EN
    if ($urandom_range(0, 9) != 0) up = BASE;
`endif
    a = up | (32'($urandom_range(0, 15)) << 3) | 32'($urandom_range(0, 7));
    return rq(a, $urandom_range(0, 1) == 1, {$urandom, $urandom}, 8'($urandom));
  endfunction

  function automatic vec_t mk(input bit rst, input logic [1:0] vld, input tcm_req_t p0, input tcm_req_t p1,
                              input logic [1:0] e_rdy, input logic [1:0] e_rsp, input bit chk_d, input logic [63:0] e_d);
    vec_t v;
    v.rst = rst; v.tchk = 1'b1; v.s.vld = vld; v.s.p0 = p0; v.s.p1 = p1;
    v.e_rdy = e_rdy; v.e_rsp = e_rsp; v.chk_d = chk_d; v.e_d = e_d;
    return v;
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_pend = 1'b0; m_id = 1'b0; m_err = 1'b0; m_dchk = 1'b0; m_rd = '0;
  endtask

  task automatic drive(input stim_t s);
    bus.req_vld = s.vld;
    bus.req_addr[0] = s.p0.addr;  bus.req_we[0] = s.p0.we;
    bus.req_wdata[0] = s.p0.wdata; bus.req_wbe[0] = s.p0.wbe;
    bus.req_addr[1] = s.p1.addr;  bus.req_we[1] = s.p1.we;
    bus.req_wdata[1] = s.p1.wdata; bus.req_wbe[1] = s.p1.wbe;
  endtask

  task automatic do_reset();
    bus.req_vld = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Called at the negedge: checks this cycle against the model, then advances the model.
  task automatic model_step(input stim_t s, output logic [1:0] eg);
    int g; bit acc, inr; tcm_req_t r; int idx;
    acc = s.vld != 2'b00;
    if (s.vld == 2'b11) g = m_last ? 0 : 1;
    else                g = s.vld[1] ? 1 : 0;
    eg  = acc ? 2'(1 << g) : 2'b00;
    r   = g ? s.p1 : s.p0;
    inr = in_win(r.addr);
    idx = int'((r.addr >> 3) & ((1 << AW) - 1));
    chk("req_rdy", 64'(bus.req_rdy), 64'(eg));
    chk("mem_cs", 64'(mem_cs), 64'(acc && inr));
    chk("mem_we", 64'(mem_we), 64'(acc && r.we));
    if (acc && inr) chk("mem_addr", 64'(mem_addr), 64'(idx));
    if (acc && r.we) begin
      chk("mem_wbe", 64'(mem_wbe), 64'(r.wbe));
      if (inr) chk("mem_wdata", mem_wdata, r.wdata);
    end
    if (!acc) chk("mem_wbe_idle", 64'(mem_wbe), 64'h0);
    chk("rsp_vld", 64'(bus.rsp_vld), m_pend ? 64'(1 << m_id) : 64'h0);
    if (m_pend && m_dchk) chk("rsp_rdata", bus.rsp_rdata, m_rd);
`ifdef TCM_ARB_RANGE_CHECK_EN
    chk("rsp_err", 64'(bus.rsp_err), 64'(m_pend && m_err));
`endif
    m_pend = acc;
    if (acc) begin
      m_last = g[0]; m_id = g[0]; m_err = !inr;
      m_dchk = !r.we || !inr;
      if (!inr)       m_rd = '0;
      else if (!r.we) m_rd = ref_mem[idx];
      else            ref_mem[idx] = merge(ref_mem[idx], r.wdata, r.wbe);
    end
  endtask

  task automatic apply(input vec_t v, output logic [1:0] eg);
    if (v.rst) do_reset();
    drive(v.s);
    @(negedge clk);
    if (v.tchk) begin
      chk("tbl_rdy", 64'(bus.req_rdy), 64'(v.e_rdy));
      chk("tbl_rsp_vld", 64'(bus.rsp_vld), 64'(v.e_rsp));
      if (v.chk_d) chk("tbl_rdata", bus.rsp_rdata, v.e_d);
    end
    model_step(v.s, eg);
    @(posedge clk); #1;
  endtask

  vec_t tbl [10];

  initial begin
    logic [1:0] eg;
    tcm_req_t   z;
    vec_t       v;
    int         cnt0, cnt1, idle;
    z = rq(32'h0, 1'b0, 64'h0, 8'h0);
    for (int i = 0; i < (1 << AW); i++) begin sram[i] = '0; ref_mem[i] = '0; end
    v = mk(1'b0, 2'b00, z, z, 2'b00, 2'b00, 1'b0, 64'h0);
    v.tchk = 1'b0;
    drive(v.s);
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'h0);
    chk("rst_mem_cs", 64'(mem_cs), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    chk("rst_mem_wbe", 64'(mem_wbe), 64'h0);
    @(posedge clk); #1;

    // Single port, byte lanes, then a fresh-reset tie.
    tbl[0] = mk(1, 2'b10, z, rq(32'h9000_0960, 1, 64'h1, 8'h0F), 2'b10, 2'b00, 0, 0);
    tbl[1] = mk(0, 2'b10, z, rq(32'h9000_0960, 0, 64'h0, 8'h00), 2'b10, 2'b10, 0, 0);
    tbl[2] = mk(0, 2'b01, rq(32'h9000_0008, 1, 64'h0123_4567_89AB_CDEF, 8'hFF), z, 2'b01, 2'b10, 1, 64'h1);
    tbl[3] = mk(0, 2'b01, rq(32'h9000_0010, 1, 64'hFEDC_BA98_7654_3210, 8'hFF), z, 2'b01, 2'b01, 0, 0);
    tbl[4] = mk(0, 2'b01, rq(32'h9000_0020, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0), z, 2'b01, 2'b01, 0, 0);
    tbl[5] = mk(0, 2'b01, rq(32'h9000_0020, 0, 64'h0, 8'h00), z, 2'b01, 2'b01, 0, 0);
    tbl[6] = mk(0, 2'b00, z, z, 2'b00, 2'b01, 1, 64'hFFFF_FFFF_0000_0000);
    tbl[7] = mk(1, 2'b11, rq(32'h9000_0008, 0, 0, 0), rq(32'h9000_0010, 0, 0, 0), 2'b01, 2'b00, 0, 0);
    tbl[8] = mk(0, 2'b10, z, rq(32'h9000_0010, 0, 0, 0), 2'b10, 2'b01, 1, 64'h0123_4567_89AB_CDEF);
    tbl[9] = mk(0, 2'b00, z, z, 2'b00, 2'b10, 1, 64'hFEDC_BA98_7654_3210);
    for (int i = 0; i < 10; i++) apply(tbl[i], eg);

    // Sustained contention: both ports always valid, losers hold their request.
    v.tchk = 1'b0; v.rst = 1'b0;
    v.s.vld = 2'b11;
    v.s.p0 = rq(32'h9000_0000 | 32'(8 * 1), 0, 0, 0);
    v.s.p1 = rq(32'h9000_0000 | 32'(8 * 2), 0, 0, 0);
    cnt0 = 0; cnt1 = 0; idle = 0;
    for (int c = 0; c < 8; c++) begin
      apply(v, eg);
      if (eg[0]) v.s.p0 = rq(32'h9000_0000 | 32'($urandom_range(0, 15) * 8), 0, 0, 0);
      if (eg[1]) v.s.p1 = rq(32'h9000_0000 | 32'($urandom_range(0, 15) * 8), 0, 0, 0);
    end
    v.s.vld = 2'b00;
    apply(v, eg);

    // Count grants independently through a second contention burst.
    v.s.vld = 2'b11;
    for (int c = 0; c < 8; c++) begin
      drive(v.s);
      @(negedge clk);
      cnt0 += int'(bus.req_rdy[0]);
      cnt1 += int'(bus.req_rdy[1]);
      idle += int'(bus.req_rdy == 2'b00);
      model_step(v.s, eg);
      @(posedge clk); #1;
    end
    chk("contend_p0_grants", 64'(cnt0), 64'd4);
    chk("contend_p1_grants", 64'(cnt1), 64'd4);
    chk("contend_idle", 64'(idle), 64'd0);
    v.s.vld = 2'b00;
    apply(v, eg);

    // Reset lands while a read response is pending.
    v.s.vld = 2'b01;
    v.s.p0 = rq(32'h9000_0008, 0, 0, 0);
    apply(v, eg);
    chk("pre_rst_rsp_vld", 64'(bus.rsp_vld), 64'h1);
    bus.req_vld = 2'b00;
    reset = 1'b1;
    #1;
    chk("rst_kills_rsp", 64'(bus.rsp_vld), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_rsp_stays_low", 64'(bus.rsp_vld), 64'h0);
    @(posedge clk); #1;
    apply(mk(0, 2'b11, rq(32'h9000_0008, 0, 0, 0), rq(32'h9000_0010, 0, 0, 0), 2'b01, 2'b00, 0, 0), eg);

`ifdef TCM_ARB_RANGE_CHECK_EN
    v.s.vld = 2'b01;
    v.s.p0 = rq(32'h8000_0000, 0, 0, 0);
    apply(v, eg);
    chk("range_rsp_vld", 64'(bus.rsp_vld), 64'h1);
    chk("range_rsp_err", 64'(bus.rsp_err), 64'h1);
    chk("range_rdata", bus.rsp_rdata, 64'h0);
`endif

    // Random traffic; a non-granted valid request is held unchanged.
    v.s.vld = 2'b00;
    eg = 2'b00;
    for (int c = 0; c < 400; c++) begin
      if (!(v.s.vld[0] && !eg[0])) begin v.s.p0 = rnd_req(); v.s.vld[0] = $urandom_range(0, 3) != 0; end
      if (!(v.s.vld[1] && !eg[1])) begin v.s.p1 = rnd_req(); v.s.vld[1] = $urandom_range(0, 3) != 0; end
      apply(v, eg);
    end
    v.s.vld = 2'b00;
    apply(v, eg);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
